// File: rtl/bit_stuffer_if.sv
// Upstream-encoder / line-driver handshake bundle for the bit stuffer.
interface bit_stuffer_if;
  logic start;
  logic endr;
  logic s_in;
  logic pause;
  logic s_out;
  logic s_valid;
  logic eop;
  logic busy;

  modport master (
    output start, endr, s_in,
    input  pause, s_out, s_valid, eop, busy
  );

  modport slave (
    input  start, endr, s_in,
    output pause, s_out, s_valid, eop, busy
  );
endinterface

// File: rtl/bit_stuffer.sv
// Serial bit stuffer: inserts a 0 after every six consecutive accepted ones,
// stalling the upstream encoder with pause while the stuff bit goes out.
module bit_stuffer (
  input  logic         clk,
  input  logic         rst_n,
  bit_stuffer_if.slave bus
);

  typedef enum logic [2:0] {IDLE, RUN, STUFF, EOP, HOLD} state_e;

  state_e     state_q, state_d;
  logic [2:0] ones_cnt_q, ones_cnt_d;
  logic       s_out_q, s_out_d;
  logic       s_valid_q, s_valid_d;
  logic       eop_q, eop_d;
  logic       busy_q, busy_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ones_cnt_q <= '0;
      s_out_q    <= 1'b0;
      s_valid_q  <= 1'b0;
      eop_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ones_cnt_q <= ones_cnt_d;
      s_out_q    <= s_out_d;
      s_valid_q  <= s_valid_d;
      eop_q      <= eop_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ones_cnt_d = ones_cnt_q;
    s_out_d    = 1'b0;
    s_valid_d  = 1'b0;
    eop_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d    = RUN;
          ones_cnt_d = '0;
        end
      end
      RUN: begin
        if (bus.endr) begin
          // No bit is pending, so eop can go out while sitting in EOP.
          state_d = EOP;
          eop_d   = 1'b1;
        end else begin
          s_out_d   = bus.s_in;
          s_valid_d = 1'b1;
          if (bus.s_in) begin
            ones_cnt_d = ones_cnt_q + 3'd1;
            if (ones_cnt_q == 3'd5) begin
              state_d = STUFF;
            end
          end else begin
            ones_cnt_d = '0;
          end
        end
      end
      STUFF: begin
        s_valid_d  = 1'b1;
        ones_cnt_d = '0;
        state_d    = bus.endr ? EOP : RUN;
      end
      EOP: begin
        // Entered from STUFF the stuff bit occupies this cycle, so eop slips one.
        eop_d   = ~eop_q;
        state_d = HOLD;
      end
      HOLD: begin
        if (!bus.endr) begin
          state_d    = IDLE;
          ones_cnt_d = '0;
        end
      end
      default: begin
        state_d    = IDLE;
        ones_cnt_d = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus.pause   = (state_q == STUFF);
  assign bus.s_out   = s_out_q;
  assign bus.s_valid = s_valid_q;
  assign bus.eop     = eop_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_bit_stuffer.sv
// Directed self-checking bench for bit_stuffer.
module tb_bit_stuffer;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  bit_stuffer_if bus ();

  bit_stuffer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic st, input logic en, input logic si);
    bus.start = st;
    bus.endr  = en;
    bus.s_in  = si;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] outs();
    return 32'({bus.s_out, bus.s_valid, bus.eop, bus.busy, bus.pause});
  endfunction

  // Sends n bits (MSB first) honouring pause, then raises endr until eop.
  task automatic packet(input logic [15:0] bits, input int n, input logic mid_start,
                        output logic [31:0] cap, output int nv, output int np,
                        output int first_p, output int gap);
    int   idx;
    int   acc;
    logic b;
    cap = '0; nv = 0; np = 0; first_p = -1; gap = 0; idx = n - 1; acc = 0;
    cyc(1'b1, 1'b0, 1'b0);
    chk("start_state", 32'({bus.s_valid, bus.busy, bus.pause}), 32'b010);
    for (int k = 0; k < 64 && idx >= 0; k++) begin
      if (bus.pause) begin
        np++;
        if (first_p < 0) first_p = acc;
        cyc(1'b0, 1'b0, 1'b1);
        chk("stuff_bit", 32'({bus.s_valid, bus.s_out}), 32'b10);
      end else begin
        b = bits[idx];
        cyc(mid_start && acc == 1, 1'b0, b);
        chk("bit_latency", 32'({bus.s_valid, bus.s_out}), 32'({1'b1, b}));
        idx--;
        acc++;
      end
      if (bus.s_valid) begin cap = {cap[30:0], bus.s_out}; nv++; end
    end
    chk("bits_sent", 32'(idx < 0), 32'd1);
    for (int k = 1; k <= 8 && gap == 0; k++) begin
      if (bus.pause) begin
        np++;
        if (first_p < 0) first_p = acc;
      end
      cyc(1'b0, 1'b1, 1'b0);
      if (bus.s_valid) begin cap = {cap[30:0], bus.s_out}; nv++; end
      if (bus.eop) gap = k;
    end
    chk("eop_seen", 32'(gap != 0), 32'd1);
    cyc(1'b0, 1'b1, mid_start);
    chk("hold_eop_low", 32'({bus.eop, bus.busy, bus.s_valid}), 32'b010);
    cyc(mid_start, 1'b1, 1'b0);
    chk("hold_start_ign", 32'({bus.eop, bus.busy, bus.s_valid}), 32'b010);
    cyc(1'b0, 1'b0, 1'b0);
    chk("back_idle", outs(), 32'd0);
    cyc(1'b0, 1'b0, 1'b1);
    chk("idle_quiet", outs(), 32'd0);
  endtask

  initial begin
    logic [31:0] cap;
    int nv, np, fp, gap;
    n_checks = 0;
    n_fail   = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.endr  = 1'b0;
    bus.s_in  = 1'b0;

    #2;
    chk("reset_outs", outs(), 32'd0);
    #10 rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b1);
    chk("idle_no_start", outs(), 32'd0);

    // 0000_0001 with start re-pulsed mid-packet and in HOLD
    packet(16'h0001, 8, 1'b1, cap, nv, np, fp, gap);
    chk("p1_stream", cap, 32'h01);
    chk("p1_count", nv, 32'd8);
    chk("p1_pause", np, 32'd0);
    chk("p1_eop_gap", gap, 32'd1);

    // seven ones
    packet(16'h007F, 7, 1'b0, cap, nv, np, fp, gap);
    chk("p2_stream", cap, 32'hFD);
    chk("p2_count", nv, 32'd8);
    chk("p2_pause", np, 32'd1);
    chk("p2_pause_pos", fp, 32'd6);
    chk("p2_eop_gap", gap, 32'd1);

    // six ones, endr right after: stuff bit must precede eop
    packet(16'h003F, 6, 1'b0, cap, nv, np, fp, gap);
    chk("p3_stream", cap, 32'h7E);
    chk("p3_count", nv, 32'd7);
    chk("p3_pause", np, 32'd1);
    chk("p3_eop_gap", gap, 32'd2);

    // sixteen ones: two stuffs
    packet(16'hFFFF, 16, 1'b0, cap, nv, np, fp, gap);
    chk("p4_stream", cap, 32'h3F7EF);
    chk("p4_count", nv, 32'd18);
    chk("p4_pause", np, 32'd2);
    chk("p4_pause_pos", fp, 32'd6);
    chk("p4_eop_gap", gap, 32'd1);

    // reset asserted during RUN
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    chk("run_before_rst", 32'({bus.s_valid, bus.s_out, bus.busy}), 32'b111);
    #2 rst_n = 1'b0;
    #1 chk("rst_in_run", outs(), 32'd0);
    cyc(1'b1, 1'b0, 1'b1);
    chk("rst_held", outs(), 32'd0);
    #2 rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    chk("after_rst_idle", outs(), 32'd0);

    // reset asserted during STUFF
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 1'b1);
    chk("stuff_pause", 32'(bus.pause), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("rst_in_stuff", outs(), 32'd0);
    #2 rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    chk("after_rst2_idle", outs(), 32'd0);

    // recovery: ones count must have been cleared by reset
    packet(16'h003F, 6, 1'b0, cap, nv, np, fp, gap);
    chk("p5_stream", cap, 32'h7E);
    chk("p5_count", nv, 32'd7);
    chk("p5_eop_gap", gap, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bit_stuffer.md
BIT_STUFFER -- requirements
Module: bit_stuffer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; all other ports are listed below.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  one-cycle pulse from the upstream encoder; first packet bit follows on the next cycle.
REQ-005 endr  input  1  from the upstream encoder; high = no further packet bits; held high until the packet is sent.
REQ-006 s_in  input  1  serial packet bit; valid every RUN cycle with endr=0 and pause=0.
REQ-007 pause  output  1  combinational; high = upstream must hold its current bit, no shift.
REQ-008 s_out  output  1  registered stuffed serial bit to the line driver.
REQ-009 s_valid  output  1  registered; s_out carries a bit this cycle.
REQ-010 eop  output  1  registered one-cycle pulse; last stuffed bit has been emitted.
REQ-011 busy  output  1  registered; high in every state except IDLE.

Function
REQ-012 States: IDLE, RUN, STUFF, EOP, HOLD; encoded state plus 3-bit ones_cnt (0..6).
REQ-013 IDLE: start=1 -> RUN with ones_cnt=0; otherwise stay; endr and s_in are ignored.
REQ-014 RUN, endr=0: accept s_in; next cycle s_out=s_in and s_valid=1 (latency exactly 1 cycle).
REQ-015 RUN accepted bit=1: ones_cnt increments; if the new value is 6 -> STUFF, else stay in RUN.
REQ-016 RUN accepted bit=0: ones_cnt=0; stay in RUN.
REQ-017 STUFF: pause=1 combinationally for exactly this cycle; s_in is ignored.
REQ-018 STUFF: next cycle s_out=0 and s_valid=1; ones_cnt=0.
REQ-019 STUFF exit: -> EOP if endr=1, else -> RUN.
REQ-020 A pending stuff bit is always emitted before eop, including when the sixth one is the packet's last bit.
REQ-021 RUN, endr=1: accept no bit; s_valid=0 next cycle; -> EOP.
REQ-022 EOP: eop=1 for one cycle, emitted after the final s_valid cycle; -> HOLD.
REQ-023 HOLD: stay while endr=1; endr=0 -> IDLE.
REQ-024 pause is low in every state except STUFF.
REQ-025 start outside IDLE is ignored; there is no restart mid-packet.
REQ-026 Output bits per packet = input bits + floor-count of stuffs; each stuff follows exactly six consecutive accepted ones.
REQ-027 A stuffed 0 resets the run, so each run of six ones is counted separately (a 12-one run produces 2 stuffs).
REQ-028 Ones runs span byte boundaries; ones_cnt is cleared only by a 0, a stuff bit, or IDLE entry.

Reset
REQ-029 rst_n=0 SHALL immediately force state=IDLE, ones_cnt=0, s_out=0, s_valid=0, eop=0, busy=0, pause=0, in any state including STUFF and HOLD.
REQ-030 After rst_n deasserts, the block SHALL wait in IDLE for start; no bit is emitted before start.

Verification
REQ-031 Reset asserted during RUN -> all outputs 0 in the same cycle; remains in IDLE until start.
REQ-032 start, then bits 0000_0001, then endr -> 8 s_valid cycles with s_out=0000_0001, each one cycle after its input; pause never high; eop on the cycle after endr is seen.
REQ-033 start, then 7 ones, then endr -> pause high one cycle after the 6th one; output stream 1111_1101, i.e. 8 bits.
REQ-034 start, then 6 ones, with endr asserted right after -> output 1111_110; eop follows the stuffed 0.
REQ-035 start, then 16 ones -> stuffs after the 6th and 12th ones; 18 output bits; pause high exactly 2 cycles.
REQ-036 start pulsed during RUN and HOLD -> no effect; the next packet starts only after endr drops and the block is in IDLE.
